// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS controller.
// Opcodes, functs, ALU/PC-source codes, FSM states, instruction classes.
package mips_ctrl_pkg;

  localparam int AluW   = 4;
  localparam int PcSrcW = 2;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [AluW-1:0] ALU_ADD = 4'd0;
  localparam logic [AluW-1:0] ALU_SUB = 4'd1;
  localparam logic [AluW-1:0] ALU_AND = 4'd2;
  localparam logic [AluW-1:0] ALU_OR  = 4'd3;
  localparam logic [AluW-1:0] ALU_XOR = 4'd4;
  localparam logic [AluW-1:0] ALU_SLT = 4'd5;

  localparam logic [PcSrcW-1:0] PC_SEQ = 2'd0;
  localparam logic [PcSrcW-1:0] PC_BR  = 2'd1;
  localparam logic [PcSrcW-1:0] PC_JMP = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_RTYPE,
    CL_IARITH,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_JUMP,
    CL_HALT
  } instr_class_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational op/funct decoder for the multi-cycle controller.
// Produces instruction class, ALU op, extender mode and legality.
module ctrl_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]      op,
  input  logic [5:0]      funct,
  output instr_class_t    cls,
  output logic [AluW-1:0] aluOp,
  output logic            ieuU,
  output logic            legal
);

  // Map opcode (and funct for R-type) to control class and ALU fields
  always_comb begin
    cls   = CL_RTYPE;
    aluOp = ALU_ADD;
    ieuU  = 1'b0;
    legal = 1'b1;
    unique case (1'b1)
      (op == OP_RTYPE): begin
        cls = CL_RTYPE;
        case (funct)
          FN_ADD:  aluOp = ALU_ADD;
          FN_SUB:  aluOp = ALU_SUB;
          FN_AND:  aluOp = ALU_AND;
          FN_OR:   aluOp = ALU_OR;
          FN_XOR:  aluOp = ALU_XOR;
          FN_SLT:  aluOp = ALU_SLT;
          default: legal = 1'b0;
        endcase
      end
      (op == OP_ADDI): begin
        cls   = CL_IARITH;
        aluOp = ALU_ADD;
      end
      (op == OP_SLTI): begin
        cls   = CL_IARITH;
        aluOp = ALU_SLT;
      end
      (op == OP_ANDI): begin
        cls   = CL_IARITH;
        aluOp = ALU_AND;
        ieuU  = 1'b1;
      end
      (op == OP_ORI): begin
        cls   = CL_IARITH;
        aluOp = ALU_OR;
        ieuU  = 1'b1;
      end
      (op == OP_XORI): begin
        cls   = CL_IARITH;
        aluOp = ALU_XOR;
        ieuU  = 1'b1;
      end
      (op == OP_LW): begin
        cls   = CL_LOAD;
        aluOp = ALU_ADD;
      end
      (op == OP_SW): begin
        cls   = CL_STORE;
        aluOp = ALU_ADD;
      end
      (op == OP_BEQ),
      (op == OP_BNE): begin
        cls   = CL_BRANCH;
        aluOp = ALU_SUB;
      end
      (op == OP_J): begin
        cls  = CL_JUMP;
        ieuU = 1'b1;
      end
      (op == OP_HALT): begin
        cls = CL_HALT;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for the MIPS core.
// Owns the shared memory port and all datapath enables and muxes.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_OP_W = 4,
  parameter int PC_SRC_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instr,
  input  logic                mem_ack,
  input  logic                alu_zero,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_sel,
  output logic                ir_we,
  output logic                pc_we,
  output logic [PC_SRC_W-1:0] pc_src,
  output logic                ieu_u,
  output logic                alu_src_imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_we,
  output logic                reg_dst_rt,
  output logic                wb_mem,
  output logic                illegal_op,
  output logic                halted,
  output logic [2:0]          state_o
);

  state_t          state;
  state_t          nextState;
  logic [5:0]      opReg;
  logic [5:0]      functReg;

  instr_class_t    curCls;
  logic [AluW-1:0] curAluOp;
  logic            curIeuU;
  logic            curLegal;

  instr_class_t    regCls;
  logic [AluW-1:0] regAluOp;
  logic            regIeuU;
  logic            regLegal;

  logic            isBne;
  logic            useImm;

  ctrl_decoder uDecCur (
    .op    (instr[31:26]),
    .funct (instr[5:0]),
    .cls   (curCls),
    .aluOp (curAluOp),
    .ieuU  (curIeuU),
    .legal (curLegal)
  );

  ctrl_decoder uDecReg (
    .op    (opReg),
    .funct (functReg),
    .cls   (regCls),
    .aluOp (regAluOp),
    .ieuU  (regIeuU),
    .legal (regLegal)
  );

  assign isBne  = (opReg == OP_BNE);
  assign useImm = (regCls == CL_IARITH) ||
                  (regCls == CL_LOAD) ||
                  (regCls == CL_STORE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= nextState;
  end

  // Latch op/funct in DECODE so EXEC..WB see a stable instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      opReg    <= '0;
      functReg <= '0;
    end else if (state == S_DECODE) begin
      opReg    <= instr[31:26];
      functReg <= instr[5:0];
    end
  end

  // Next-state and output decode; all outputs forced low while in reset
  always_comb begin
    nextState    = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_SRC_W'(PC_SEQ);
    ieu_u        = 1'b0;
    alu_src_imm  = 1'b0;
    alu_op       = ALU_OP_W'(ALU_ADD);
    reg_we       = 1'b0;
    reg_dst_rt   = 1'b0;
    wb_mem       = 1'b0;
    illegal_op   = 1'b0;
    halted       = 1'b0;
    state_o      = 3'd0;
    if (!rst) begin
      state_o = state;
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_we     = 1'b1;
            pc_we     = 1'b1;
            nextState = S_DECODE;
          end
        end
        S_DECODE: begin
          if (!curLegal) begin
            illegal_op = 1'b1;
            nextState  = S_FETCH;
          end else if (curCls == CL_HALT) begin
            nextState = S_HALT;
          end else begin
            nextState = S_EXEC;
          end
        end
        S_EXEC: begin
          alu_op      = ALU_OP_W'(regAluOp);
          alu_src_imm = useImm;
          ieu_u       = regIeuU;
          case (regCls)
            CL_RTYPE,
            CL_IARITH: nextState = S_WB;
            CL_LOAD,
            CL_STORE:  nextState = S_MEM;
            CL_BRANCH: begin
              pc_we     = alu_zero ^ isBne;
              pc_src    = PC_SRC_W'(PC_BR);
              nextState = S_FETCH;
            end
            CL_JUMP: begin
              pc_we     = 1'b1;
              pc_src    = PC_SRC_W'(PC_JMP);
              nextState = S_FETCH;
            end
            default: nextState = S_FETCH;
          endcase
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (regCls == CL_STORE);
          alu_op       = ALU_OP_W'(regAluOp);
          alu_src_imm  = useImm;
          ieu_u        = regIeuU;
          if (mem_ack) begin
            nextState = (regCls == CL_STORE) ? S_FETCH : S_WB;
          end
        end
        S_WB: begin
          reg_we     = 1'b1;
          wb_mem     = (regCls == CL_LOAD);
          reg_dst_rt = (regCls != CL_RTYPE);
          nextState  = S_FETCH;
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: nextState = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl.
// Inputs change 1ns after posedge; outputs sampled on negedge.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        mem_ack = 1'b0;
  logic        alu_zero = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic        ieu_u;
  logic        alu_src_imm;
  logic [3:0]  alu_op;
  logic        reg_we;
  logic        reg_dst_rt;
  logic        wb_mem;
  logic        illegal_op;
  logic        halted;
  logic [2:0]  state_o;

  int nCmp = 0;
  int nBad = 0;
  int cyc  = 0;
  int cycStart;

  multicycle_ctrl #(.ALU_OP_W(4), .PC_SRC_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr        (instr),
    .mem_ack      (mem_ack),
    .alu_zero     (alu_zero),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_we        (ir_we),
    .pc_we        (pc_we),
    .pc_src       (pc_src),
    .ieu_u        (ieu_u),
    .alu_src_imm  (alu_src_imm),
    .alu_op       (alu_op),
    .reg_we       (reg_we),
    .reg_dst_rt   (reg_dst_rt),
    .wb_mem       (wb_mem),
    .illegal_op   (illegal_op),
    .halted       (halted),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nCmp++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] encI(input logic [5:0] op,
                                       input logic [17:0] imm);
    return {op, 4'd1, 4'd2, imm};
  endfunction

  function automatic logic [31:0] encR(input logic [5:0] fn);
    return {6'h00, 4'd1, 4'd2, 4'd3, 8'h00, fn};
  endfunction

  task automatic fetch(input logic [31:0] iw);
    instr   = iw;
    mem_ack = 1'b1;
    @(negedge clk);
    chk("fetch.state", state_o, 0);
    chk("fetch.mem_req", mem_req, 1);
    chk("fetch.addr_sel", mem_addr_sel, 0);
    chk("fetch.ir_we", ir_we, 1);
    chk("fetch.pc_we", pc_we, 1);
    chk("fetch.pc_src", pc_src, 0);
    chk("fetch.illegal", illegal_op, 0);
    tick;
    mem_ack = 1'b0;
  endtask

  task automatic decode;
    @(negedge clk);
    chk("dec.state", state_o, 1);
    chk("dec.illegal", illegal_op, 0);
    chk("dec.mem_req", mem_req, 0);
    chk("dec.ir_we", ir_we, 0);
    tick;
  endtask

  task automatic branch(input logic [5:0] op, input logic z,
                        input logic expWe);
    fetch(encI(op, 18'h00010));
    decode;
    alu_zero = z;
    @(negedge clk);
    chk("br.state", state_o, 2);
    chk("br.pc_we", pc_we, expWe);
    chk("br.pc_src", pc_src, 1);
    chk("br.alu_op", alu_op, 1);
    chk("br.ieu_u", ieu_u, 0);
    tick;
    alu_zero = 1'b0;
  endtask

  initial begin
    // reset
    repeat (2) tick;
    @(negedge clk);
    chk("rst.state", state_o, 0);
    chk("rst.mem_req", mem_req, 0);
    chk("rst.ir_we", ir_we, 0);
    chk("rst.halted", halted, 0);
    tick;
    rst = 1'b0;

    // ADDI, sign-extended all-ones immediate
    cycStart = cyc;
    fetch(encI(6'h08, 18'h3FFFF));
    decode;
    @(negedge clk);
    chk("addi.state", state_o, 2);
    chk("addi.ieu_u", ieu_u, 0);
    chk("addi.src_imm", alu_src_imm, 1);
    chk("addi.alu_op", alu_op, 0);
    chk("addi.exec_reg_we", reg_we, 0);
    tick;
    @(negedge clk);
    chk("addi.wb_state", state_o, 4);
    chk("addi.reg_we", reg_we, 1);
    chk("addi.dst_rt", reg_dst_rt, 1);
    chk("addi.wb_mem", wb_mem, 0);
    tick;
    chk("addi.cycles", cyc - cycStart, 4);

    // ORI
    fetch(encI(6'h0D, 18'h3FFFF));
    decode;
    @(negedge clk);
    chk("ori.ieu_u", ieu_u, 1);
    chk("ori.alu_op", alu_op, 3);
    chk("ori.src_imm", alu_src_imm, 1);
    tick;
    @(negedge clk);
    chk("ori.reg_we", reg_we, 1);
    chk("ori.dst_rt", reg_dst_rt, 1);
    tick;

    // R-type SUB
    fetch(encR(6'h22));
    decode;
    @(negedge clk);
    chk("sub.alu_op", alu_op, 1);
    chk("sub.src_imm", alu_src_imm, 0);
    tick;
    @(negedge clk);
    chk("sub.state", state_o, 4);
    chk("sub.reg_we", reg_we, 1);
    chk("sub.dst_rt", reg_dst_rt, 0);
    tick;

    // LW with 3 wait cycles in MEM
    cycStart = cyc;
    fetch(encI(6'h23, 18'h3FFF0));
    decode;
    @(negedge clk);
    chk("lw.exec_state", state_o, 2);
    chk("lw.exec_ieu_u", ieu_u, 0);
    chk("lw.exec_alu_op", alu_op, 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      @(negedge clk);
      chk("lw.mem_state", state_o, 3);
      chk("lw.mem_req", mem_req, 1);
      chk("lw.addr_sel", mem_addr_sel, 1);
      chk("lw.mem_we", mem_we, 0);
      chk("lw.ieu_u", ieu_u, 0);
      chk("lw.src_imm", alu_src_imm, 1);
      tick;
    end
    mem_ack = 1'b0;
    @(negedge clk);
    chk("lw.wb_state", state_o, 4);
    chk("lw.wb_mem", wb_mem, 1);
    chk("lw.reg_we", reg_we, 1);
    chk("lw.dst_rt", reg_dst_rt, 1);
    tick;
    chk("lw.cycles", cyc - cycStart, 8);

    // SW, zero-wait
    cycStart = cyc;
    fetch(encI(6'h2B, 18'h00004));
    decode;
    tick;
    mem_ack = 1'b1;
    @(negedge clk);
    chk("sw.state", state_o, 3);
    chk("sw.mem_we", mem_we, 1);
    chk("sw.mem_req", mem_req, 1);
    chk("sw.reg_we", reg_we, 0);
    tick;
    mem_ack = 1'b0;
    chk("sw.cycles", cyc - cycStart, 4);

    // Branches
    branch(6'h04, 1'b1, 1'b1);
    branch(6'h04, 1'b0, 1'b0);
    branch(6'h05, 1'b1, 1'b0);
    branch(6'h05, 1'b0, 1'b1);

    // Jump
    fetch(encI(6'h02, 18'h00100));
    decode;
    @(negedge clk);
    chk("j.pc_we", pc_we, 1);
    chk("j.pc_src", pc_src, 2);
    chk("j.ieu_u", ieu_u, 1);
    tick;

    // Undefined opcode 3E
    fetch({6'h3E, 26'h0});
    @(negedge clk);
    chk("ill.state", state_o, 1);
    chk("ill.pulse", illegal_op, 1);
    chk("ill.mem_req", mem_req, 0);
    chk("ill.reg_we", reg_we, 0);
    tick;

    // Reset during MEM wait, with an ack in flight
    fetch(encI(6'h23, 18'h00008));
    decode;
    tick;
    @(negedge clk);
    chk("rmem.state", state_o, 3);
    tick;
    rst     = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    chk("rmem.gated_req", mem_req, 0);
    tick;
    @(negedge clk);
    chk("rmem.state", state_o, 0);
    chk("rmem.mem_req", mem_req, 0);
    chk("rmem.ir_we", ir_we, 0);
    chk("rmem.pc_we", pc_we, 0);
    chk("rmem.reg_we", reg_we, 0);
    tick;
    rst     = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("rmem.fetch_state", state_o, 0);
    chk("rmem.fetch_req", mem_req, 1);
    chk("rmem.fetch_ir_we", ir_we, 0);
    tick;

    // HALT for 20 cycles, then reset
    fetch({6'h3F, 26'h0});
    decode;
    for (int i = 0; i < 20; i++) begin
      mem_ack = i[0];
      @(negedge clk);
      chk("halt.state", state_o, 5);
      chk("halt.halted", halted, 1);
      chk("halt.mem_req", mem_req, 0);
      chk("halt.pc_we", pc_we, 0);
      tick;
    end
    mem_ack = 1'b0;
    rst     = 1'b1;
    tick;
    @(negedge clk);
    chk("halt.rst_state", state_o, 0);
    chk("halt.rst_halted", halted, 0);
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("halt.after_req", mem_req, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
